// File: rtl/shift_ctrl_if.sv
// ----------------------------------------------------------------------------
// shift_ctrl_if
// Bundles the horizontal-shift sequencer's inputs and outputs.
//   i_frame_tick    one-cycle pulse per video frame
//   i_keycode       current keyboard keycode (8'h00 = none)
//   i_active        a piece is falling and may move
//   i_spawn         one-cycle pulse: new piece spawned
//   i_spawn_x       x position loaded on spawn
//   i_xout_move     mover result for the current x_pos/select
//   o_select        direction select to mover (1 = left, 0 = right)
//   o_x_pos         piece x position (fed back to mover xin)
//   o_shift_event   one-cycle pulse: x_pos changed
//   o_shift_blocked one-cycle pulse: shift attempted, mover returned same x
// slave  = the sequencer, master = whoever drives it (mover/keyboard side).
// ----------------------------------------------------------------------------
interface shift_ctrl_if;
    logic       i_frame_tick;
    logic [7:0] i_keycode;
    logic       i_active;
    logic       i_spawn;
    logic [5:0] i_spawn_x;
    logic [4:0] i_xout_move;
    logic       o_select;
    logic [5:0] o_x_pos;
    logic       o_shift_event;
    logic       o_shift_blocked;

    modport slave (
        input  i_frame_tick, i_keycode, i_active, i_spawn, i_spawn_x, i_xout_move,
        output o_select, o_x_pos, o_shift_event, o_shift_blocked
    );

    modport master (
        output i_frame_tick, i_keycode, i_active, i_spawn, i_spawn_x, i_xout_move,
        input  o_select, o_x_pos, o_shift_event, o_shift_blocked
    );
endinterface

// File: rtl/shift_ctrl.sv
// ----------------------------------------------------------------------------
// shift_ctrl
// Horizontal-shift sequencer for the falling piece. Decodes the keycode into
// a left/right request, drives the mover's direction select, owns the piece
// x-position register and implements delayed auto-shift (DAS) followed by
// auto-repeat (ARR), both counted in frame_ticks.
// Ports:
//   Clk    system clock
//   Reset  synchronous, active-high
//   bus    shift_ctrl_if.slave (see interface header for signal list)
// ----------------------------------------------------------------------------
module shift_ctrl #(
    parameter logic [7:0] KEY_LEFT   = 8'h50,
    parameter logic [7:0] KEY_RIGHT  = 8'h4F,
    parameter int         DAS_FRAMES = 10,
    parameter int         ARR_FRAMES = 2,
    parameter logic [5:0] SPAWN_X    = 6'd4
) (
    input  logic          Clk,
    input  logic          Reset,
    shift_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DAS   = 2'd2,
        ST_ARR   = 2'd3
    } state_t;

    localparam logic [5:0] W_DAS_THR = 6'(DAS_FRAMES);
    localparam logic [5:0] W_ARR_THR = 6'(ARR_FRAMES);

    state_t     r_state;
    logic [5:0] r_x_pos;
    logic       r_dir;          // 1 = left, 0 = right
    logic [5:0] r_cnt;
    logic       r_first;        // next SHIFT is the initial one -> go to DAS
    logic       r_shift_event;
    logic       r_shift_blocked;

    logic       w_req_left;
    logic       w_req_right;
    logic       w_req;
    logic [5:0] w_cnt_inc;
    logic [5:0] w_thr;
    logic [5:0] w_commit_x;

    assign w_req_left  = (bus.i_keycode == KEY_LEFT);
    assign w_req_right = (bus.i_keycode == KEY_RIGHT);
    assign w_req       = w_req_left | w_req_right;

    // Counter saturates so a stuck key can never wrap it back to a threshold.
    assign w_cnt_inc  = (r_cnt == 6'd63) ? 6'd63 : r_cnt + 6'd1;
    assign w_thr      = (r_state == ST_DAS) ? W_DAS_THR : W_ARR_THR;
    assign w_commit_x = {1'b0, bus.i_xout_move};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state         <= ST_IDLE;
            r_x_pos         <= SPAWN_X;
            r_dir           <= 1'b0;
            r_cnt           <= 6'd0;
            r_first         <= 1'b0;
            r_shift_event   <= 1'b0;
            r_shift_blocked <= 1'b0;
        end else begin
            r_shift_event   <= 1'b0;
            r_shift_blocked <= 1'b0;

            if (bus.i_spawn) begin
                // Spawn wins over any pending commit. A held key does not
                // shift the new piece immediately; it has to recharge DAS.
                r_x_pos <= bus.i_spawn_x;
                r_cnt   <= 6'd0;
                r_first <= 1'b0;
                if (w_req && bus.i_active) begin
                    r_dir   <= w_req_left;
                    r_state <= ST_DAS;
                end else begin
                    r_state <= ST_IDLE;
                end
            end else if (!bus.i_active) begin
                r_state <= ST_IDLE;
                r_cnt   <= 6'd0;
                r_first <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_req) begin
                            // dir is loaded one cycle ahead of the commit so
                            // the mover sees a stable select during SHIFT.
                            r_dir   <= w_req_left;
                            r_first <= 1'b1;
                            r_state <= ST_SHIFT;
                        end
                    end

                    ST_SHIFT: begin
                        r_x_pos <= w_commit_x;
                        if (w_commit_x != r_x_pos) begin
                            r_shift_event <= 1'b1;
                        end else begin
                            r_shift_blocked <= 1'b1;
                        end
                        r_cnt   <= 6'd0;
                        r_first <= 1'b0;
                        r_state <= r_first ? ST_DAS : ST_ARR;
                    end

                    ST_DAS, ST_ARR: begin
                        if (!w_req) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 6'd0;
                        end else if (w_req_left != r_dir) begin
                            // Redirect: shift at once and restart DAS.
                            r_dir   <= w_req_left;
                            r_first <= 1'b1;
                            r_state <= ST_SHIFT;
                        end else if (bus.i_frame_tick) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == w_thr) begin
                                r_state <= ST_SHIFT;
                            end
                        end
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_select        = r_dir;
    assign bus.o_x_pos         = r_x_pos;
    assign bus.o_shift_event   = r_shift_event;
    assign bus.o_shift_blocked = r_shift_blocked;

endmodule
